// File: rtl/l2_mem_burst_ctrl.sv
// l2_mem_burst_ctrl: arbitrates L2 line fills (read bursts) and victim
// writebacks (write bursts) onto the 64-bit main-memory bus, counts
// BURST_LENGTH beats per line and signals completion.
// Optional feature macro: L2MEM_TIMEOUT_EN (abort a burst after
// TIMEOUT_CYCLES consecutive cycles without a beat, pulsing err).
module l2_mem_burst_ctrl #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 64,
    parameter int BURST_LENGTH     = 8,
    parameter int LINE_OFFSET_BITS = 6,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    // line-fill requester
    input  logic                            fill_req,
    input  logic [ADDR_WIDTH-1:0]           fill_addr,
    output logic                            fill_gnt,
    output logic [DATA_WIDTH-1:0]           fill_data,
    output logic                            fill_valid,
    output logic [$clog2(BURST_LENGTH)-1:0] fill_beat,
    output logic                            fill_done,
    // writeback requester
    input  logic                            wb_req,
    input  logic [ADDR_WIDTH-1:0]           wb_addr,
    output logic                            wb_gnt,
    input  logic [DATA_WIDTH-1:0]           wb_data,
    output logic                            wb_rd,
    output logic                            wb_done,
    // main-memory bus
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_stb,
    output logic                            err
);

    localparam int BEAT_W = $clog2(BURST_LENGTH);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFFSET_BITS;

`ifdef L2MEM_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                last_wb;      // last completed grant was a writeback
    logic                cur_wb;       // burst in flight is a writeback
    logic                aborted;      // burst in flight ended by timeout
    logic                grant_fill;
    logic                grant_wb;
    logic                in_burst;
    logic                beat;
    logic                last_beat;
    logic                timeout_hit;

    assign in_burst    = (state == RD_BURST) || (state == WR_BURST);
    assign beat        = in_burst && mem_stb;
    assign last_beat   = beat && (beat_cnt == BEAT_W'(BURST_LENGTH - 1));
    assign timeout_hit = TIMEOUT_ON && in_burst && !mem_stb &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Arbitration and next-state decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_fill = 1'b0;
        grant_wb   = 1'b0;
        state_nxt  = state;
        unique case (state)
            IDLE: begin
                // Writeback normally wins a tie; after a writeback the fill
                // path gets its turn so it cannot be starved.
                if (wb_req && (!fill_req || !last_wb)) begin
                    grant_wb  = 1'b1;
                    state_nxt = WR_BURST;
                end else if (fill_req) begin
                    grant_fill = 1'b1;
                    state_nxt  = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (last_beat || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst datapath: grants, latched bus controls, beat counter, read capture.
    always_ff @(posedge clk) begin
        // NOTE: fill_data is reset along with everything else because every
        // output must read 0 out of reset; it is a single register, not a memory.
        if (rst) begin
            fill_gnt   <= 1'b0;
            wb_gnt     <= 1'b0;
            fill_valid <= 1'b0;
            fill_data  <= '0;
            fill_beat  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            beat_cnt   <= '0;
            last_wb    <= 1'b0;
            cur_wb     <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
        end else begin
            fill_gnt   <= grant_fill;
            wb_gnt     <= grant_wb;
            fill_valid <= 1'b0;
            err        <= timeout_hit;

            if (grant_fill || grant_wb) begin
                mem_addr <= (grant_wb ? wb_addr : fill_addr) & LINE_MASK;
                mem_req  <= 1'b1;
                mem_we   <= grant_wb;
                cur_wb   <= grant_wb;
                aborted  <= 1'b0;
                beat_cnt <= '0;
            end

            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (state == RD_BURST) begin
                    fill_valid <= 1'b1;
                    fill_data  <= mem_rdata;
                    fill_beat  <= beat_cnt;
                end
            end

            if (last_beat || timeout_hit) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end

            if (timeout_hit) begin
                aborted <= 1'b1;
            end

            if (state == DONE) begin
                last_wb <= cur_wb;
            end
        end
    end

    // Inter-beat idle counter; only consulted when the timeout is compiled in.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (grant_fill || grant_wb || mem_stb) begin
            idle_cnt <= '0;
        end else if (in_burst) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Combinational handshakes toward the writeback requester and memory.
    assign wb_rd     = (state == WR_BURST) && mem_stb;
    assign mem_wdata = (state == WR_BURST) ? wb_data : '0;
    assign fill_done = (state == DONE) && !cur_wb && !aborted;
    assign wb_done   = (state == DONE) &&  cur_wb && !aborted;

endmodule
